// File: rtl/nap_timer_ctrl.sv
// Nap timer: keypad sets a countdown in seconds, '#' starts/pauses it, and
// alarm is raised when it expires. Outputs are registered from next-state values.
module nap_timer_ctrl #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned MAX_MIN  = 9,
  parameter int unsigned KEY1_SEC = 5,
  parameter int unsigned KEY2_SEC = 30,
  parameter int unsigned KEY3_SEC = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       sharp,
  output logic       timer_en,
  output logic       waiting,
  output logic       alarm,
  output logic [3:0] one_sec,
  output logic [3:0] ten_sec,
  output logic [3:0] one_min
);

  localparam int unsigned TW = 10;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] MAX_T    = TW'(MAX_MIN * 60 + 59);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] secs_q, secs_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    key_q, key_d;
  logic          sharp_q, sharp_d;
  logic          armed_q, armed_d;
  logic          waiting_q, waiting_d;
  logic          timer_en_q, timer_en_d;
  logic          alarm_q, alarm_d;
  logic [3:0]    one_sec_q, one_sec_d;
  logic [3:0]    ten_sec_q, ten_sec_d;
  logic [3:0]    one_min_q, one_min_d;

  logic          key_onehot;
  logic          key_press;
  logic          sharp_press;
  logic [TW-1:0] mins;
  logic [TW-1:0] rem;

  function automatic logic [TW-1:0] add_sat(input logic [TW-1:0] t, input int unsigned sec);
    logic [TW:0] sum;
    sum = {1'b0, t} + (TW+1)'(sec);
    return (sum > {1'b0, MAX_T}) ? MAX_T : sum[TW-1:0];
  endfunction

  // armed_q masks the first sample after reset so a held input is not a press
  assign key_onehot  = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
  assign key_press   = armed_q && key_onehot && (key_q == 10'd0);
  assign sharp_press = armed_q && sharp && !sharp_q;

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    pre_d   = pre_q;
    key_d   = keypad;
    sharp_d = sharp;
    armed_d = 1'b1;

    case (state_q)
      ST_SET: begin
        if (sharp_press) begin
          if (secs_q != TW'(0)) begin
            state_d = ST_RUN;
            pre_d   = PW'(0);
          end
        end else if (key_press) begin
          if (keypad[0])      secs_d = TW'(0);
          else if (keypad[1]) secs_d = add_sat(secs_q, KEY1_SEC);
          else if (keypad[2]) secs_d = add_sat(secs_q, KEY2_SEC);
          else if (keypad[3]) secs_d = add_sat(secs_q, KEY3_SEC);
        end
      end
      ST_RUN: begin
        if (sharp_press) begin
          state_d = ST_PAUSE;
        end else if (pre_q == PRE_LAST) begin
          pre_d = PW'(0);
          if (secs_q != TW'(0)) secs_d = secs_q - TW'(1);
          if (secs_q <= TW'(1)) state_d = ST_DONE;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (sharp_press) begin
          state_d = ST_RUN;
          pre_d   = PW'(0);
        end else if (key_press && keypad[0]) begin
          state_d = ST_SET;
          secs_d  = TW'(0);
        end
      end
      ST_DONE: begin
        secs_d = TW'(0);
        if (sharp_press || key_press) state_d = ST_SET;
      end
      default: begin
        state_d = ST_SET;
        secs_d  = TW'(0);
        pre_d   = PW'(0);
      end
    endcase

    // Outputs decoded from the next-state values so they register in step
    mins       = secs_d / TW'(60);
    rem        = secs_d - mins * TW'(60);
    one_min_d  = 4'(mins);
    ten_sec_d  = 4'(rem / TW'(10));
    one_sec_d  = 4'(rem % TW'(10));
    waiting_d  = (state_d == ST_SET);
    timer_en_d = (state_d == ST_RUN);
    alarm_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_SET;
      secs_q     <= TW'(0);
      pre_q      <= PW'(0);
      key_q      <= 10'd0;
      sharp_q    <= 1'b0;
      armed_q    <= 1'b0;
      waiting_q  <= 1'b1;
      timer_en_q <= 1'b0;
      alarm_q    <= 1'b0;
      one_sec_q  <= 4'd0;
      ten_sec_q  <= 4'd0;
      one_min_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      secs_q     <= secs_d;
      pre_q      <= pre_d;
      key_q      <= key_d;
      sharp_q    <= sharp_d;
      armed_q    <= armed_d;
      waiting_q  <= waiting_d;
      timer_en_q <= timer_en_d;
      alarm_q    <= alarm_d;
      one_sec_q  <= one_sec_d;
      ten_sec_q  <= ten_sec_d;
      one_min_q  <= one_min_d;
    end
  end

  assign waiting  = waiting_q;
  assign timer_en = timer_en_q;
  assign alarm    = alarm_q;
  assign one_sec  = one_sec_q;
  assign ten_sec  = ten_sec_q;
  assign one_min  = one_min_q;

endmodule
